// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's control, memory and decoder signals.
// The slave modport is the sequencer side; master is the environment side.
interface fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    // Control
    logic             start;
    logic [63:0]      entry_pc;
    logic             redirect;
    logic [63:0]      redirect_pc;

    // Memory request / response.
    // A request transfers on a cycle where req_valid and req_ready are both
    // high; req_valid/req_addr stay put until that happens. Exactly one
    // response (resp_valid pulse) comes back per transferred request, in order,
    // never in the transfer cycle itself.
    logic             req_valid;
    logic [63:0]      req_addr;
    logic             req_ready;
    logic             resp_valid;
    logic [63:0]      resp_data;

    // Decoder side: same valid/ready transfer rule as the request channel.
    logic             inst_valid;
    logic [31:0]      inst;
    logic [63:0]      inst_pc;
    logic             inst_ready;

    // Status
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] inst_count;

    modport slave (
        input  start, entry_pc, redirect, redirect_pc,
        input  req_ready, resp_valid, resp_data, inst_ready,
        output req_valid, req_addr, inst_valid, inst, inst_pc,
        output busy, halted, inst_count
    );

    modport master (
        output start, entry_pc, redirect, redirect_pc,
        output req_ready, resp_valid, resp_data, inst_ready,
        input  req_valid, req_addr, inst_valid, inst, inst_pc,
        input  busy, halted, inst_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches 64-bit memory words, hands out the two
// 32-bit instructions they contain, follows redirects, and halts on a zero
// instruction. o_state exposes the FSM state for observation.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.slave   bus,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT     = 3'd2,
        S_ISSUE_LO = 3'd3,
        S_ISSUE_HI = 3'd4,
        S_DRAIN    = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_pc;
    logic [63:0]      w_pc_nxt;
    logic [63:0]      r_buf;
    logic [63:0]      w_buf_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_halted;
    logic             w_halted_nxt;
    logic [31:0]      w_inst;
    logic [63:0]      w_entry_pc;
    logic [63:0]      w_redirect_pc;

    // Word-aligned versions of the incoming PCs (low two bits forced to zero)
    assign w_entry_pc    = bus.entry_pc    & ~64'h3;
    assign w_redirect_pc = bus.redirect_pc & ~64'h3;

    // State register: FSM state plus all datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_buf    <= 64'h0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_buf    <= w_buf_nxt;
            r_count  <= w_count_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Next-state logic; redirect wins over a same-cycle request or
    // instruction transfer, but a transferred instruction is still counted
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_buf_nxt    = r_buf;
        w_count_nxt  = r_count;
        w_halted_nxt = r_halted;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    w_state_nxt  = S_REQ;
                    w_pc_nxt     = w_entry_pc;
                    w_count_nxt  = '0;
                    w_halted_nxt = 1'b0;
                end
            end
            S_REQ: begin
                if (bus.redirect) begin
                    w_pc_nxt = w_redirect_pc;
                    // A request that transferred this cycle still owes a response
                    w_state_nxt = bus.req_ready ? S_DRAIN : S_REQ;
                end else if (bus.req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = bus.resp_valid ? S_REQ : S_DRAIN;
                end else if (bus.resp_valid) begin
                    w_buf_nxt   = bus.resp_data;
                    w_state_nxt = r_pc[2] ? S_ISSUE_HI : S_ISSUE_LO;
                end
            end
            S_ISSUE_LO, S_ISSUE_HI: begin
                if (bus.inst_ready) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
                if (bus.redirect) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (bus.inst_ready) begin
                    if (w_inst == 32'h0) begin
                        w_state_nxt  = S_HALT;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_pc_nxt    = r_pc + 64'd4;
                        w_state_nxt = (r_state == S_ISSUE_LO) ? S_ISSUE_HI : S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.redirect) begin
                    w_pc_nxt = w_redirect_pc;
                end
                if (bus.resp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        w_inst = 32'h0;
        if (r_state == S_ISSUE_LO) begin
            w_inst = r_buf[31:0];
        end else if (r_state == S_ISSUE_HI) begin
            w_inst = r_buf[63:32];
        end
        bus.req_valid  = (r_state == S_REQ);
        bus.req_addr   = (r_state == S_REQ) ? (r_pc & ~64'h7) : 64'h0;
        bus.inst_valid = (r_state == S_ISSUE_LO) || (r_state == S_ISSUE_HI);
        bus.inst       = w_inst;
        bus.inst_pc    = r_pc;
        bus.busy       = (r_state != S_IDLE) && (r_state != S_HALT);
        bus.halted     = r_halted;
        bus.inst_count = r_count;
        o_state        = r_state;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a memory responder with programmable
// latency, an expected-instruction queue checked on every decoder transfer,
// and directed status checks.
module tb_fetch_sequencer;
    localparam logic [63:0] RST_PC   = 64'h40;
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_WAIT  = 3'd2;
    localparam logic [2:0]  ST_HI    = 3'd4;
    localparam logic [2:0]  ST_DRAIN = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  o_state;
    int          total = 0;
    int          bad = 0;
    int          mem_lat = 1;
    int          resp_cnt = 0;
    logic [63:0] pend_addr = 64'h0;
    logic [95:0] exp_q[$];

    fetch_sequencer_if #(.CNT_W(32)) bus();

    fetch_sequencer #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus), .o_state(o_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        case (a)
            64'h1000: return {32'h0000_0013, 32'h0050_0093};
            64'h1008: return 64'h0;
            64'h2000: return {32'h0000_0000, 32'h0010_0093};
            default:  return 64'h1111_2222_3333_4444;
        endcase
    endfunction

    // memory responder: answers each transferred request after mem_lat cycles
    always @(negedge clk) begin
        bus.resp_valid = 1'b0;
        bus.resp_data  = 64'h0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = mem_rd(pend_addr);
            end
        end
        if (!reset && bus.req_valid && bus.req_ready) begin
            pend_addr = bus.req_addr;
            resp_cnt  = mem_lat;
        end
    end

    // scoreboard: every decoder transfer must match the head of exp_q
    always @(negedge clk) begin
        logic [95:0] e;
        if (!reset && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_inst observed=%0h@%0h expected=none", bus.inst, bus.inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("inst", {32'h0, bus.inst}, {32'h0, e[31:0]});
                check("inst_pc", bus.inst_pc, e[95:32]);
            end
        end
        if (!reset) begin
            check("req_inst_exclusive", {63'h0, bus.req_valid && bus.inst_valid}, 64'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] ins);
        exp_q.push_back({pc, ins});
    endtask

    task automatic start_fetch(input logic [63:0] pc);
        bus.entry_pc = pc;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return bus.halted;
            1:       return bus.inst_valid;
            2:       return o_state == ST_WAIT;
            default: return bus.req_valid;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int max);
        int n = 0;
        while (!cond(sel) && n < max) begin
            step();
            n++;
        end
        if (!cond(sel)) begin
            total++;
            bad++;
            $error("FAIL %s timeout observed=not_seen expected=seen_within_%0d", tag, max);
        end
    endtask

    task automatic push_basic();
        push(64'h1000, 32'h0050_0093);
        push(64'h1004, 32'h0000_0013);
        push(64'h1008, 32'h0000_0000);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.entry_pc    = 64'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'h0;
        bus.req_ready   = 1'b1;
        bus.inst_ready  = 1'b1;
        step();
        step();

        // reset state
        check("rst_req_valid", {63'h0, bus.req_valid}, 64'h0);
        check("rst_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
        check("rst_busy", {63'h0, bus.busy}, 64'h0);
        check("rst_halted", {63'h0, bus.halted}, 64'h0);
        check("rst_count", {32'h0, bus.inst_count}, 64'h0);
        check("rst_inst_pc", bus.inst_pc, RST_PC);
        check("rst_req_addr", bus.req_addr, 64'h0);
        reset = 1'b0;
        step();

        // basic fetch: two instructions then a zero halts
        push_basic();
        start_fetch(64'h1000);
        check("t1_req_valid", {63'h0, bus.req_valid}, 64'h1);
        check("t1_req_addr", bus.req_addr, 64'h1000);
        check("t1_busy", {63'h0, bus.busy}, 64'h1);
        wait_for("t1_halt", 0, 100);
        check("t1_halted", {63'h0, bus.halted}, 64'h1);
        check("t1_count", {32'h0, bus.inst_count}, 64'd3);
        check("t1_pc_hold", bus.inst_pc, 64'h1008);
        check("t1_busy_off", {63'h0, bus.busy}, 64'h0);
        check("t1_q_empty", 64'(exp_q.size()), 64'h0);

        // start at the upper half of a word
        push(64'h1004, 32'h0000_0013);
        push(64'h1008, 32'h0000_0000);
        start_fetch(64'h1004);
        check("t2_req_addr", bus.req_addr, 64'h1000);
        wait_for("t2_halt", 0, 100);
        check("t2_count", {32'h0, bus.inst_count}, 64'd2);
        check("t2_q_empty", 64'(exp_q.size()), 64'h0);

        // decoder stall holds the instruction steady
        bus.inst_ready = 1'b0;
        push_basic();
        start_fetch(64'h1000);
        wait_for("t3_valid", 1, 50);
        for (int i = 0; i < 5; i++) begin
            check("t3_inst_hold", {32'h0, bus.inst}, 64'h0050_0093);
            check("t3_pc_hold", bus.inst_pc, 64'h1000);
            check("t3_count_hold", {32'h0, bus.inst_count}, 64'h0);
            check("t3_no_req", {63'h0, bus.req_valid}, 64'h0);
            step();
        end
        bus.inst_ready = 1'b1;
        wait_for("t3_halt", 0, 100);
        check("t3_count", {32'h0, bus.inst_count}, 64'd3);
        check("t3_q_empty", 64'(exp_q.size()), 64'h0);

        // redirect while waiting; late response must be dropped
        mem_lat = 3;
        push(64'h2000, 32'h0010_0093);
        push(64'h2004, 32'h0000_0000);
        start_fetch(64'h1000);
        wait_for("t4_wait", 2, 20);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h2002;
        step();
        bus.redirect = 1'b0;
        mem_lat      = 1;
        check("t4_drain", {61'h0, o_state}, {61'h0, ST_DRAIN});
        wait_for("t4_req", 3, 20);
        check("t4_req_addr", bus.req_addr, 64'h2000);
        wait_for("t4_halt", 0, 100);
        check("t4_count", {32'h0, bus.inst_count}, 64'd2);
        check("t4_q_empty", 64'(exp_q.size()), 64'h0);

        // redirect together with a zero-instruction transfer: counted, no halt
        bus.inst_ready = 1'b0;
        push(64'h1008, 32'h0000_0000);
        push(64'h2000, 32'h0010_0093);
        push(64'h2004, 32'h0000_0000);
        start_fetch(64'h1008);
        wait_for("t5_valid", 1, 50);
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h2000;
        step();
        bus.redirect = 1'b0;
        check("t5_no_halt", {63'h0, bus.halted}, 64'h0);
        check("t5_count", {32'h0, bus.inst_count}, 64'd1);
        check("t5_req_valid", {63'h0, bus.req_valid}, 64'h1);
        check("t5_req_addr", bus.req_addr, 64'h2000);
        wait_for("t5_halt", 0, 100);
        check("t5_count_end", {32'h0, bus.inst_count}, 64'd3);
        check("t5_q_empty", 64'(exp_q.size()), 64'h0);

        // reset while presenting the upper half
        bus.inst_ready = 1'b0;
        push(64'h1004, 32'h0000_0013);
        start_fetch(64'h1004);
        wait_for("t6_valid", 1, 50);
        check("t6_in_hi", {61'h0, o_state}, {61'h0, ST_HI});
        reset = 1'b1;
        #1;
        check("t6_state", {61'h0, o_state}, {61'h0, ST_IDLE});
        check("t6_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
        check("t6_inst", {32'h0, bus.inst}, 64'h0);
        check("t6_inst_pc", bus.inst_pc, RST_PC);
        check("t6_busy", {63'h0, bus.busy}, 64'h0);
        check("t6_count", {32'h0, bus.inst_count}, 64'h0);
        exp_q.delete();
        step();
        reset = 1'b0;
        bus.inst_ready = 1'b1;
        push_basic();
        start_fetch(64'h1000);
        check("t6_req_addr", bus.req_addr, 64'h1000);
        wait_for("t6_halt", 0, 100);
        check("t6_count_end", {32'h0, bus.inst_count}, 64'd3);
        check("t6_q_empty", 64'(exp_q.size()), 64'h0);

        // reset with a request outstanding; its response lands in IDLE
        mem_lat = 3;
        start_fetch(64'h1000);
        wait_for("t7_wait", 2, 20);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        mem_lat = 1;
        for (int i = 0; i < 4; i++) step();
        check("t7_idle", {61'h0, o_state}, {61'h0, ST_IDLE});
        check("t7_no_inst", {63'h0, bus.inst_valid}, 64'h0);
        push_basic();
        start_fetch(64'h1000);
        wait_for("t7_halt", 0, 100);
        check("t7_count", {32'h0, bus.inst_count}, 64'd3);
        check("t7_q_empty", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end
endmodule
